// File: rtl/link_credit_flow_ctrl_if.sv
// Flit handshake bundle between link_credit_flow_ctrl and its neighbours.
//   data  : flit payload
//   valid : producer offers a flit/packet
//   ready : consumer accepts it this cycle
// The master modport is the producer side; the slave modport is the consumer side.
interface link_credit_flow_ctrl_if #(
  parameter type data_t = logic
);
  data_t data;
  logic  valid;
  logic  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/link_credit_flow_ctrl.sv
// Credit-based flow controller for one virtual channel of a serial link.
// Gates outgoing flits on credits granted by the remote receive buffer, counts local
// receive-buffer pops as credits to return, and forces a credit-only packet when return
// credits pile up with no data to carry them. Flits pass through combinationally.
//
// Ports:
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   noc_io (slave)           : flits from the NoC (data_i / data_valid_i / data_ready_o)
//   link_io (master)         : packets to the link arbiter (data_o / data_valid_o / data_ready_i)
//   credit_send_o            : pending credits to return to the remote side
//   credits_only_packet_o    : offered packet carries credits only
//   req_cred_to_buffer_msg   : local buffer pops generate return credits
//   credit_rcvd_i,
//   receive_cred_i           : credits granted by remote, added when the pulse is high
//   buffer_queue_out_val_i,
//   buffer_queue_out_rdy_i   : local receive-buffer pop handshake
//   allow_cred_consume_i     : this channel owns the shared header's credit field
//   consume_cred_to_send_i   : credit_send_o was handed off; clear pending credits
module link_credit_flow_ctrl #(
  parameter type         credit_t         = logic [3:0],
  parameter type         data_t           = logic,
  parameter int unsigned NumCredits       = 8,
  parameter int unsigned ForceSendThresh  = 4,
  parameter bit          CredOnlyConsCred = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  link_credit_flow_ctrl_if.slave         noc_io,
  link_credit_flow_ctrl_if.master        link_io,
  output credit_t                        credit_send_o,
  output logic                           credits_only_packet_o,
  input  logic                           req_cred_to_buffer_msg,
  input  credit_t                        credit_rcvd_i,
  input  logic                           receive_cred_i,
  input  logic                           buffer_queue_out_val_i,
  input  logic                           buffer_queue_out_rdy_i,
  input  logic                           allow_cred_consume_i,
  input  logic                           consume_cred_to_send_i
);

  localparam int unsigned CW = $bits(credit_t);
  // One extra bit so remote grants can be summed before saturation.
  typedef logic [CW:0] sum_t;

  localparam sum_t    MaxAvail  = sum_t'(NumCredits);
  localparam credit_t InitAvail = credit_t'(NumCredits);
  localparam credit_t Thresh    = credit_t'(ForceSendThresh);
  localparam credit_t PendMax   = '1;

  credit_t avail_q, avail_d;
  credit_t pend_q, pend_d;
  sum_t    avail_sum;
  logic    have, data_offer, send_data, send_co, cred_dec, pop;

  assign have       = (avail_q != '0);
  assign data_offer = noc_io.valid & have;

  // Data always wins the slot; a credit-only packet fills it only when no flit can go.
  assign credits_only_packet_o = allow_cred_consume_i & (pend_q >= Thresh) & ~data_offer &
                                 (have | ~CredOnlyConsCred);

  assign link_io.data  = noc_io.data;
  assign link_io.valid = data_offer | credits_only_packet_o;

  assign send_data    = link_io.ready & data_offer & ~credits_only_packet_o;
  assign noc_io.ready = send_data;
  assign send_co      = credits_only_packet_o & link_io.ready;
  assign cred_dec     = send_data | (send_co & CredOnlyConsCred);

  assign pop = buffer_queue_out_val_i & buffer_queue_out_rdy_i & req_cred_to_buffer_msg;

  assign credit_send_o = pend_q;

  always_comb begin
    avail_sum = sum_t'(avail_q) + (receive_cred_i ? sum_t'(credit_rcvd_i) : '0) -
                sum_t'(cred_dec);
    avail_d   = (avail_sum > MaxAvail) ? InitAvail : credit_t'(avail_sum[CW-1:0]);
  end

  // A pop in the same cycle as a handoff starts the new count rather than being dropped.
  always_comb begin
    pend_d = pend_q;
    if (consume_cred_to_send_i) begin
      pend_d = credit_t'(pop);
    end else if (pop && (pend_q != PendMax)) begin
      pend_d = pend_q + credit_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      avail_q <= InitAvail;
      pend_q  <= '0;
    end else begin
      avail_q <= avail_d;
      pend_q  <= pend_d;
    end
  end

  a_avail_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    avail_sum <= MaxAvail);

  a_avail_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cred_dec && !have));

  // A stalled offer must not change under the arbiter unless the credit state moved.
  a_offer_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (link_io.valid && !link_io.ready) |=>
      ($stable(link_io.data) && $stable(credits_only_packet_o)) ||
      !$stable(avail_q) || !$stable(pend_q));

endmodule

// File: tb/tb_link_credit_flow_ctrl.sv
module tb_link_credit_flow_ctrl;

  localparam int NCRED  = 8;
  localparam int THRESH = 4;
  localparam bit CO_CONS = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] credit_send_o;
  logic       credits_only_packet_o;
  logic       req_cred_to_buffer_msg = 1'b0;
  logic [3:0] credit_rcvd_i = '0;
  logic       receive_cred_i = 1'b0;
  logic       bval = 1'b0;
  logic       brdy = 1'b0;
  logic       allow = 1'b0;
  logic       consume = 1'b0;

  link_credit_flow_ctrl_if #(.data_t(logic)) noc_if ();
  link_credit_flow_ctrl_if #(.data_t(logic)) link_if ();

  link_credit_flow_ctrl u_dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .noc_io                 (noc_if),
    .link_io                (link_if),
    .credit_send_o          (credit_send_o),
    .credits_only_packet_o  (credits_only_packet_o),
    .req_cred_to_buffer_msg (req_cred_to_buffer_msg),
    .credit_rcvd_i          (credit_rcvd_i),
    .receive_cred_i         (receive_cred_i),
    .buffer_queue_out_val_i (bval),
    .buffer_queue_out_rdy_i (brdy),
    .allow_cred_consume_i   (allow),
    .consume_cred_to_send_i (consume)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int flit_cnt = 0;

  // Behavioural model: remote credits and pending return credits as plain integers.
  int m_avail = NCRED;
  int m_pend  = 0;
  int n_avail = NCRED;
  int n_pend  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare outputs mid-cycle, then work out what the model holds after the next edge.
  always @(negedge clk) begin
    bit have, e_co, e_vo, e_ro, sc;
    int na;
    have = (m_avail > 0);
    e_co = allow && (m_pend >= THRESH) && !(noc_if.valid && have) && (have || !CO_CONS);
    e_vo = (noc_if.valid && have) || e_co;
    e_ro = link_if.ready && noc_if.valid && have && !e_co;
    chk("credits_only", int'(credits_only_packet_o), int'(e_co));
    chk("data_valid_o", int'(link_if.valid), int'(e_vo));
    chk("data_ready_o", int'(noc_if.ready), int'(e_ro));
    chk("credit_send_o", int'(credit_send_o), m_pend);
    chk("data_o", int'(link_if.data), int'(noc_if.data));
    if (noc_if.ready) flit_cnt++;
    sc = e_co && link_if.ready;
    na = m_avail - int'(e_ro) - int'(sc && CO_CONS) + (receive_cred_i ? int'(credit_rcvd_i) : 0);
    n_avail <= (na > NCRED) ? NCRED : na;
    n_pend  <= (consume ? 0 : m_pend) + int'(bval && brdy && req_cred_to_buffer_msg);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_avail <= NCRED;
      m_pend  <= 0;
    end else begin
      m_avail <= n_avail;
      m_pend  <= n_pend;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    noc_if.data   = 1'b0;
    noc_if.valid  = 1'b0;
    link_if.ready = 1'b0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset credit_send", int'(credit_send_o), 0);
    chk("reset credits_only", int'(credits_only_packet_o), 0);
    tick(1);

    // Eight credits drain with continuous traffic, then data stalls.
    noc_if.valid  = 1'b1;
    link_if.ready = 1'b1;
    flit_cnt = 0;
    repeat (10) begin
      noc_if.data = ~noc_if.data;
      tick(1);
    end
    chk("flits from reset", flit_cnt, 8);
    chk("model avail drained", m_avail, 0);
    @(negedge clk);
    chk("stall ready", int'(noc_if.ready), 0);
    chk("stall valid", int'(link_if.valid), 0);
    tick(1);

    // Three credits granted while stalled: exactly three flits follow.
    flit_cnt = 0;
    receive_cred_i = 1'b1;
    credit_rcvd_i  = 4'd3;
    tick(1);
    receive_cred_i = 1'b0;
    tick(6);
    chk("flits after grant", flit_cnt, 3);

    // Refill, then four pops force a credit-only packet.
    noc_if.valid   = 1'b0;
    link_if.ready  = 1'b0;
    receive_cred_i = 1'b1;
    credit_rcvd_i  = 4'd8;
    tick(1);
    receive_cred_i = 1'b0;
    chk("model avail refill", m_avail, 8);
    req_cred_to_buffer_msg = 1'b1;
    allow = 1'b1;
    bval  = 1'b1;
    brdy  = 1'b1;
    tick(4);
    bval = 1'b0;
    @(negedge clk);
    chk("pend four", int'(credit_send_o), 4);
    chk("co raised", int'(credits_only_packet_o), 1);
    chk("co valid", int'(link_if.valid), 1);
    tick(1);
    link_if.ready = 1'b1;
    consume = 1'b1;
    tick(1);
    link_if.ready = 1'b0;
    consume = 1'b0;
    @(negedge clk);
    chk("pend cleared", int'(credit_send_o), 0);
    chk("co dropped", int'(credits_only_packet_o), 0);
    chk("avail kept", m_avail, 8);
    tick(1);

    // Consume and pop in the same cycle with pend=5 leaves one.
    allow = 1'b0;
    bval  = 1'b1;
    tick(5);
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    bval = 1'b0;
    @(negedge clk);
    chk("consume plus pop", int'(credit_send_o), 1);
    tick(1);

    // pend=6 with data and credits: data goes, no credit-only packet.
    bval = 1'b1;
    tick(5);
    bval = 1'b0;
    allow = 1'b1;
    noc_if.valid  = 1'b1;
    link_if.ready = 1'b1;
    @(negedge clk);
    chk("pend six", int'(credit_send_o), 6);
    chk("data beats co", int'(credits_only_packet_o), 0);
    chk("data accepted", int'(noc_if.ready), 1);
    tick(1);
    noc_if.valid  = 1'b0;
    link_if.ready = 1'b0;
    allow = 1'b0;
    chk("avail after one", m_avail, 7);

    // Pops without the credit request are not counted.
    req_cred_to_buffer_msg = 1'b0;
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
    bval = 1'b1;
    tick(3);
    bval = 1'b0;
    @(negedge clk);
    chk("no req no pend", int'(credit_send_o), 0);
    tick(1);

    // Send and receive in one cycle: 1 - 1 + 3 = 3.
    flit_cnt = 0;
    noc_if.valid  = 1'b1;
    link_if.ready = 1'b1;
    tick(6);
    chk("flits to one", flit_cnt, 6);
    chk("model avail one", m_avail, 1);
    receive_cred_i = 1'b1;
    credit_rcvd_i  = 4'd3;
    tick(1);
    receive_cred_i = 1'b0;
    chk("model net update", m_avail, 3);
    flit_cnt = 0;
    tick(5);
    chk("flits after net", flit_cnt, 3);

    // Asynchronous reset mid-transfer restores counters immediately.
    req_cred_to_buffer_msg = 1'b1;
    bval = 1'b1;
    tick(2);
    bval = 1'b0;
    chk("pend before rst", int'(credit_send_o), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst pend", int'(credit_send_o), 0);
    chk("async rst ready", int'(noc_if.ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    noc_if.valid  = 1'b0;
    link_if.ready = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
